corr_peak_finder: RTL and testbench
===================================

Name: corr_peak_finder

Overview:
- Sits directly upstream of the code-phase controller.
- Scans one frame of NBINS signed correlation sums, one per code-offset bin from the correlator adder tree.
- Picks the bin of largest magnitude and presents it as max_id and max_sum.
- Pulses adder_flag for one cycle, so the controller steps phase exactly once per frame.

Parameters:
- NBINS, 128, number of correlation bins per frame; 2..256.
- SUM_W, 32, width of the signed correlation sum; must match the controller's max_sum width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a new frame scan; honoured only in IDLE.
- sum_valid  in  1  sum_in carries the next bin's sum this cycle.
- sum_in  in  SUM_W  signed correlation sum for the current bin.
- busy  out  1  high in SCAN and DONE.
- max_id  out  8  index of the winning bin, 0..NBINS-1.
- max_sum  out  SUM_W  signed sum of the winning bin, original sign kept.
- adder_flag  out  1  one-cycle pulse: max_id/max_sum were updated this cycle.

Behaviour:
- Reset: clk and rst as decided above (synchronous, active-high).
  - State goes to IDLE.
  - busy, max_id, max_sum, adder_flag all 0.
  - Internal bin counter and best registers cleared.
  - rst asserted mid-SCAN aborts the frame; no adder_flag is produced for it.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN when start=1. Bin counter and best_mag cleared; best_id set to 0.
  - A sum_valid in the same cycle as start (in IDLE) is not accepted.
  - SCAN: each cycle with sum_valid=1 accepts one sample with index = bin counter, then the counter increments.
  - sum_valid=0 stalls SCAN with no state change. There is no timeout.
  - SCAN -> DONE on the cycle the sample with index NBINS-1 is accepted.
  - DONE (exactly 1 cycle):
    - max_id <= best_id; max_sum <= best_sum.
    - adder_flag asserted during DONE only, i.e. 1 cycle after the last sample is accepted.
    - DONE -> IDLE unconditionally.
  - start while busy is ignored; it is not queued.
  - sum_valid in IDLE or DONE is ignored.
- Comparison:
  - mag = |sum_in|, computed at SUM_W bits.
  - The most negative value (-2^(SUM_W-1)) saturates to 2^(SUM_W-1)-1.
  - Update the best registers when mag > best_mag (strictly greater), so ties keep the lower index.
  - Bin 0 always loads the best registers, which makes an all-zero frame report id 0, sum 0.
  - The incoming sample is compared against the best registers as updated by the previous accepted sample (no bypass hazard).
- Hold: max_id/max_sum hold their last values between frames and change only during DONE.
- Index width: max_id is zero-extended to 8 bits.

Optional Feature:
- Macro: PEAK_NOISE_ACC_EN.
- Defined:
  - Adds output port noise_sum (SUM_W+8 bits, unsigned).
  - noise_sum is the sum of mag over all accepted bins of the frame, accumulated at full width (no overflow for NBINS<=256).
  - Accumulator cleared on start; noise_sum loaded in DONE together with max_*.
  - noise_sum resets to 0.
  - Gives software a noise-floor estimate.
- Undefined: port absent, no accumulator logic. All other behaviour identical.

Test Plan:
- Reset check: rst held 3 cycles -> max_id=0, max_sum=0, adder_flag=0, busy=0.
- Single peak: start, then 128 back-to-back samples, all 10 except bin 40 = 5000 -> adder_flag pulses once, 1 cycle after bin 127; max_id=40, max_sum=5000; busy falls with DONE.
- Negative peak and tie: bin 100 = -9000 and bin 20 = 9000, others 0 -> max_id=20, max_sum=9000. Swap to bin 20 = 8999 -> max_id=100, max_sum=-9000.
- Saturation: bin 7 = -2^31, bin 8 = 2^31-1 -> max_id=7, max_sum=-2147483648.
- Stalls and stray control: sum_valid toggled 1010..., start pulsed mid-scan, sum_valid=1 in IDLE -> exactly one adder_flag after the 128th accepted sample; result unaffected by the stray start and IDLE samples.
- Abort: rst at bin 60 of frame A (peak at bin 10), then a full frame B with peak at bin 90 = 3000 -> no flag for A; max_id=90, max_sum=3000. With PEAK_NOISE_ACC_EN defined and all bins = -2 -> noise_sum=256.

Source files
------------

// File: rtl/corr_peak_finder.sv
// rtl/corr_peak_finder.sv - largest-magnitude bin finder over one correlation frame
//
// Scans NBINS signed correlation sums (one per code-offset bin), keeps the bin
// of largest magnitude, and publishes it once per frame with a one-cycle
// adder_flag pulse so the code-phase controller steps exactly once per frame.
//
// Optional build macro: PEAK_NOISE_ACC_EN adds noise_sum, the full-width sum of
// all bin magnitudes of the frame (noise-floor estimate).
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a frame scan (honoured only when idle)
//   sum_valid   sum_in carries the next bin's sum this cycle
//   sum_in      signed correlation sum of the current bin
//   busy        high while scanning and during the result cycle
//   max_id      index of the winning bin, zero-extended to 8 bits
//   max_sum     signed sum of the winning bin, sign preserved
//   adder_flag  one-cycle pulse: max_id/max_sum hold a fresh result
//   noise_sum   (PEAK_NOISE_ACC_EN only) sum of |sum_in| over the frame

module corr_peak_finder #(
    parameter int NBINS = 128,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sum_valid,
    input  logic [SUM_W-1:0] sum_in,
    output logic             busy,
    output logic [7:0]       max_id,
    output logic [SUM_W-1:0] max_sum,
    output logic             adder_flag
`ifdef PEAK_NOISE_ACC_EN
    ,
    output logic [SUM_W+7:0] noise_sum
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(NBINS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       cnt_q, cnt_d;
    logic [SUM_W-1:0] best_mag_q, best_mag_d;
    logic [7:0]       best_id_q, best_id_d;
    logic [SUM_W-1:0] best_sum_q, best_sum_d;
    logic [7:0]       max_id_q, max_id_d;
    logic [SUM_W-1:0] max_sum_q, max_sum_d;

`ifdef PEAK_NOISE_ACC_EN
    logic [SUM_W+7:0] acc_q, acc_d;
    logic [SUM_W+7:0] noise_q, noise_d;
`endif

    logic [SUM_W-1:0] neg_val;
    logic [SUM_W-1:0] mag;
    logic             accept;
    logic             better;
    logic             last_bin;

    // Magnitude at SUM_W bits. Negating the most negative value wraps back to
    // itself (MSB still set), which is the one case that saturates.
    always_comb begin
        neg_val = ~sum_in + 1'b1;
        if (!sum_in[SUM_W-1]) begin
            mag = sum_in;
        end else if (neg_val[SUM_W-1]) begin
            mag = {1'b0, {(SUM_W-1){1'b1}}};
        end else begin
            mag = neg_val;
        end
    end

    assign accept   = (state_q == S_SCAN) && sum_valid;
    assign last_bin = (cnt_q == LAST_IDX);
    // Bin 0 always loads; afterwards only a strictly larger magnitude wins,
    // so ties keep the lower index.
    assign better   = (cnt_q == 8'd0) || (mag > best_mag_q);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SCAN;
            S_SCAN: if (accept && last_bin) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = 1'b0;
        adder_flag = 1'b0;
        case (state_q)
            S_SCAN: busy = 1'b1;
            S_DONE: begin
                busy       = 1'b1;
                adder_flag = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next state. The published result is captured on the same edge
    // that accepts the last bin, from the best values including that bin, so
    // max_id/max_sum are already valid during the cycle adder_flag is high.
    always_comb begin
        cnt_d      = cnt_q;
        best_mag_d = best_mag_q;
        best_id_d  = best_id_q;
        best_sum_d = best_sum_q;
        max_id_d   = max_id_q;
        max_sum_d  = max_sum_q;
`ifdef PEAK_NOISE_ACC_EN
        acc_d      = acc_q;
        noise_d    = noise_q;
`endif
        if ((state_q == S_IDLE) && start) begin
            cnt_d      = 8'd0;
            best_mag_d = '0;
            best_id_d  = 8'd0;
            best_sum_d = '0;
`ifdef PEAK_NOISE_ACC_EN
            acc_d      = '0;
`endif
        end else if (accept) begin
            cnt_d = cnt_q + 8'd1;
            if (better) begin
                best_mag_d = mag;
                best_id_d  = cnt_q;
                best_sum_d = sum_in;
            end
`ifdef PEAK_NOISE_ACC_EN
            acc_d = acc_q + {8'd0, mag};
`endif
            if (last_bin) begin
                max_id_d  = best_id_d;
                max_sum_d = best_sum_d;
`ifdef PEAK_NOISE_ACC_EN
                noise_d   = acc_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 8'd0;
            best_mag_q <= '0;
            best_id_q  <= 8'd0;
            best_sum_q <= '0;
            max_id_q   <= 8'd0;
            max_sum_q  <= '0;
`ifdef PEAK_NOISE_ACC_EN
            acc_q      <= '0;
            noise_q    <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            best_mag_q <= best_mag_d;
            best_id_q  <= best_id_d;
            best_sum_q <= best_sum_d;
            max_id_q   <= max_id_d;
            max_sum_q  <= max_sum_d;
`ifdef PEAK_NOISE_ACC_EN
            acc_q      <= acc_d;
            noise_q    <= noise_d;
`endif
        end
    end

    assign max_id  = max_id_q;
    assign max_sum = max_sum_q;
`ifdef PEAK_NOISE_ACC_EN
    assign noise_sum = noise_q;
`endif

endmodule

// File: tb/tb_corr_peak_finder.sv
// tb/tb_corr_peak_finder.sv - self-checking bench for corr_peak_finder

module tb_corr_peak_finder;

    localparam int NB = 128;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sum_valid;
    logic [SW-1:0] sum_in;
    logic          busy;
    logic [7:0]    max_id;
    logic [SW-1:0] max_sum;
    logic          adder_flag;
`ifdef PEAK_NOISE_ACC_EN
    logic [SW+7:0] noise_sum;
`endif

    int checks   = 0;
    int failures = 0;
    int flag_cnt = 0;

    logic signed [SW-1:0] frame [NB];

    typedef struct {
        string                name;
        int                   mode;   // bit0 stall 1010, bit1 stray start, bit2 valid with start
        logic signed [SW-1:0] bg;
        int                   ia;
        logic signed [SW-1:0] va;
        int                   ib;
        logic signed [SW-1:0] vb;
        int                   exp_id;
        logic signed [SW-1:0] exp_sum;
    } vec_t;

    vec_t vecs [9];

    corr_peak_finder #(.NBINS(NB), .SUM_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sum_valid  (sum_valid),
        .sum_in     (sum_in),
        .busy       (busy),
        .max_id     (max_id),
        .max_sum    (max_sum),
        .adder_flag (adder_flag)
`ifdef PEAK_NOISE_ACC_EN
        ,
        .noise_sum  (noise_sum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (adder_flag === 1'b1) flag_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint mag_of(input logic signed [SW-1:0] s);
        longint v;
        v = s;
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    // Reference: first bin holding the maximum magnitude, plus total magnitude.
    task automatic model(output int id, output logic signed [SW-1:0] sum, output longint noise);
        longint best;
        best  = -1;
        id    = 0;
        sum   = '0;
        noise = 0;
        for (int i = 0; i < NB; i++) begin
            longint m;
            m = mag_of(frame[i]);
            noise += m;
            if (m > best) begin
                best = m;
                id   = i;
                sum  = frame[i];
            end
        end
    endtask

    task automatic fill(input logic signed [SW-1:0] bg, input int ia, input logic signed [SW-1:0] va,
                        input int ib, input logic signed [SW-1:0] vb);
        for (int i = 0; i < NB; i++) frame[i] = bg;
        if (ia >= 0) frame[ia] = va;
        if (ib >= 0) frame[ib] = vb;
    endtask

    task automatic run_frame(input string nm, input int mode, input int exp_id,
                             input logic signed [SW-1:0] exp_sum, input longint exp_noise);
        int idx;
        int cyc;
        int f0;
        bit v;
        logic [7:0]    hold_id;
        logic [SW-1:0] hold_sum;
        f0 = flag_cnt;
        @(negedge clk);
        start     = 1'b1;
        sum_valid = ((mode & 4) != 0);
        sum_in    = 32'h7fff_ffff;
        @(negedge clk);
        chk({nm, " busy_scan"}, longint'(busy), 1);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (idx < NB && cyc < 2000) begin
            v         = ((mode & 1) == 0) || (cyc % 2 == 0);
            sum_valid = v;
            sum_in    = v ? frame[idx] : $urandom;
            start     = ((mode & 2) != 0) && (cyc == 50 || cyc == 51);
            @(negedge clk);
            if (v) idx++;
            cyc++;
        end
        sum_valid = 1'b0;
        start     = 1'b0;
        if (idx < NB) chk({nm, " timeout"}, idx, NB);
        chk({nm, " flag"},    longint'(adder_flag), 1);
        chk({nm, " busy_done"}, longint'(busy), 1);
        chk({nm, " max_id"},  longint'(max_id), exp_id);
        chk({nm, " max_sum"}, longint'($signed(max_sum)), exp_sum);
`ifdef PEAK_NOISE_ACC_EN
        chk({nm, " noise"},   longint'(noise_sum), exp_noise);
`endif
        hold_id  = max_id;
        hold_sum = max_sum;
        @(negedge clk);
        chk({nm, " flag_low"}, longint'(adder_flag), 0);
        chk({nm, " idle"},     longint'(busy), 0);
        // samples presented while idle must be ignored
        sum_valid = 1'b1;
        sum_in    = 32'h7fff_ffff;
        repeat (3) @(negedge clk);
        sum_valid = 1'b0;
        #1;
        chk({nm, " one_flag"}, flag_cnt - f0, 1);
        chk({nm, " hold_id"},  longint'(max_id), longint'(hold_id));
        chk({nm, " hold_sum"}, longint'(max_sum), longint'(hold_sum));
    endtask

    initial begin
        int                   id;
        logic signed [SW-1:0] s;
        longint               nz;
        int                   f0;

        vecs[0] = '{"single_peak", 0, 10,  40, 5000,  -1, 0,    40, 5000};
        vecs[1] = '{"neg_tie",     0, 0,  100, -9000, 20, 9000, 20, 9000};
        vecs[2] = '{"neg_wins",    0, 0,  100, -9000, 20, 8999, 100, -9000};
        vecs[3] = '{"saturate",    0, 0,    7, 32'sh8000_0000, 8, 32'sh7fff_ffff, 7, 32'sh8000_0000};
        vecs[4] = '{"stall_stray", 7, 10,  40, 5000,  -1, 0,    40, 5000};
        vecs[5] = '{"all_zero",    1, 0,   -1, 0,     -1, 0,    0, 0};
        vecs[6] = '{"last_bin",    0, 0,  127, 1,     -1, 0,    127, 1};
        vecs[7] = '{"all_tie",     2, -5,  -1, 0,     -1, 0,    0, -5};
        vecs[8] = '{"all_neg2",    0, -2,  -1, 0,     -1, 0,    0, -2};

        rst       = 1'b1;
        start     = 1'b0;
        sum_valid = 1'b0;
        sum_in    = '0;
        repeat (3) @(negedge clk);
        chk("reset max_id",     longint'(max_id), 0);
        chk("reset max_sum",    longint'(max_sum), 0);
        chk("reset adder_flag", longint'(adder_flag), 0);
        chk("reset busy",       longint'(busy), 0);
`ifdef PEAK_NOISE_ACC_EN
        chk("reset noise",      longint'(noise_sum), 0);
`endif
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            fill(vecs[k].bg, vecs[k].ia, vecs[k].va, vecs[k].ib, vecs[k].vb);
            model(id, s, nz);
            run_frame(vecs[k].name, vecs[k].mode, vecs[k].exp_id, vecs[k].exp_sum, nz);
        end

        // abort: frame A reset at bin 60, then a full frame B
        fill(0, 10, 7777, -1, 0);
        f0 = flag_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sum_valid = 1'b1;
            sum_in    = frame[i];
            @(negedge clk);
        end
        rst    = 1'b1;
        sum_in = frame[60];
        @(negedge clk);
        rst       = 1'b0;
        sum_valid = 1'b0;
        chk("abort busy",    longint'(busy), 0);
        chk("abort flag",    longint'(adder_flag), 0);
        chk("abort max_id",  longint'(max_id), 0);
        chk("abort max_sum", longint'(max_sum), 0);
        fill(0, 90, 3000, -1, 0);
        model(id, s, nz);
        run_frame("abort_b", 0, 90, 3000, nz);
        #1;
        chk("abort total_flags", flag_cnt - f0, 1);

        // randomized frames against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NB; i++) begin
                if (r % 2 == 0) frame[i] = $urandom;
                else            frame[i] = $signed($urandom_range(0, 40)) - 20;
            end
            if (r == 5) frame[$urandom_range(0, NB - 1)] = 32'sh8000_0000;
            model(id, s, nz);
            run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 7)), id, s, nz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
